// File: rtl/mem_access_unit_if.sv
// Request/response handshake and BRAM-port bundle for mem_access_unit.
// The slave modport is the unit's view; master is the CPU plus memory side.
interface mem_access_unit_if #(
    parameter int MEM_SIZE  = 8192,
    parameter int MEM_WIDTH = 32
);
    localparam int ADDR_W = $clog2(MEM_SIZE);
    localparam int EN_W   = MEM_WIDTH >> 2;

    logic                 req_valid;
    logic                 req_ready;
    logic [31:0]          req_addr;
    logic                 req_write;
    logic [1:0]           req_size;
    logic                 req_unsigned;
    logic [31:0]          req_wdata;

    logic                 resp_valid;
    logic                 resp_ready;
    logic [31:0]          resp_rdata;
    logic                 resp_fault;

    logic [ADDR_W-1:0]    mem_addr;
    logic [MEM_WIDTH-1:0] mem_data_o;
    logic [EN_W-1:0]      mem_data_en;
    logic                 mem_write_en;
    logic [MEM_WIDTH-1:0] mem_data_i;

    modport slave (
        input  req_valid, req_addr, req_write, req_size, req_unsigned, req_wdata,
        input  resp_ready, mem_data_i,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_addr, mem_data_o, mem_data_en, mem_write_en
    );

    modport master (
        output req_valid, req_addr, req_write, req_size, req_unsigned, req_wdata,
        output resp_ready, mem_data_i,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_addr, mem_data_o, mem_data_en, mem_write_en
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer for one BRAM port: range check, one-cycle access strobe,
// one-cycle read wait, then a held response with sign/zero-extended load data.
module mem_access_unit #(
    parameter int MEM_SIZE  = 8192,
    parameter int MEM_WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    mem_access_unit_if.slave bus
);
    localparam int ADDR_W = $clog2(MEM_SIZE);
    localparam int EN_W   = MEM_WIDTH >> 2;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t          state;
    logic [1:0]      size_q;
    logic            unsigned_q;
    logic            write_q;

    logic [2:0]      nbytes;
    logic [EN_W-1:0] req_en;
    logic [32:0]     end_addr;
    logic            req_fault;
    logic [31:0]     load_data;

    // The range check is done one bit wider than the address so a request
    // near 0xFFFFFFFF cannot wrap around and look legal.
    always_comb begin
        nbytes = 3'd4;
        req_en = EN_W'(4'hF);
        case (bus.req_size)
            2'b00: begin
                nbytes = 3'd1;
                req_en = EN_W'(4'h1);
            end
            2'b01: begin
                nbytes = 3'd2;
                req_en = EN_W'(4'h3);
            end
            default: ;
        endcase
        end_addr  = {1'b0, bus.req_addr} + 33'(nbytes);
        req_fault = (bus.req_size == 2'b11) || (end_addr > 33'(MEM_SIZE));
    end

    always_comb begin
        load_data = bus.mem_data_i[31:0];
        case (size_q)
            2'b00:   load_data = {{24{bus.mem_data_i[7] & ~unsigned_q}}, bus.mem_data_i[7:0]};
            2'b01:   load_data = {{16{bus.mem_data_i[15] & ~unsigned_q}}, bus.mem_data_i[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            size_q           <= 2'b00;
            unsigned_q       <= 1'b0;
            write_q          <= 1'b0;
            bus.req_ready    <= 1'b1;
            bus.resp_valid   <= 1'b0;
            bus.resp_rdata   <= '0;
            bus.resp_fault   <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_data_o   <= '0;
            bus.mem_data_en  <= '0;
            bus.mem_write_en <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        bus.req_ready <= 1'b0;
                        size_q        <= bus.req_size;
                        unsigned_q    <= bus.req_unsigned;
                        write_q       <= bus.req_write;
                        // Faulting requests never touch the memory port.
                        if (req_fault) begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_fault <= 1'b1;
                            bus.resp_rdata <= '0;
                        end else begin
                            state            <= ACCESS;
                            bus.resp_fault   <= 1'b0;
                            bus.mem_addr     <= bus.req_addr[ADDR_W-1:0];
                            bus.mem_data_en  <= req_en;
                            bus.mem_write_en <= bus.req_write;
                            if (bus.req_write)
                                bus.mem_data_o <= MEM_WIDTH'(bus.req_wdata);
                        end
                    end
                end
                ACCESS: begin
                    bus.mem_write_en <= 1'b0;
                    bus.mem_data_en  <= '0;
                    if (write_q) begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_rdata <= '0;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    state          <= RESP;
                    bus.resp_valid <= 1'b1;
                    bus.resp_rdata <= load_data;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state          <= IDLE;
                        bus.resp_valid <= 1'b0;
                        bus.req_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: a byte-array reference model predicts every
// response and per-cycle port activity, with a BRAM model answering the memory port.
module tb_mem_access_unit;
    localparam int MEM_SIZE  = 8192;
    localparam int MEM_WIDTH = 32;

    logic clk;
    logic rst;

    mem_access_unit_if #(.MEM_SIZE(MEM_SIZE), .MEM_WIDTH(MEM_WIDTH)) bus ();

    mem_access_unit #(.MEM_SIZE(MEM_SIZE), .MEM_WIDTH(MEM_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;

    logic [7:0] bram    [0:MEM_SIZE-1];
    logic [7:0] ref_mem [0:MEM_SIZE-1];

    // Expectations for the transaction in flight, consumed by the monitor.
    bit          txn_active = 1'b0;
    bit          mon_off    = 1'b1;
    int          cyc        = 0;
    int          exp_lat    = 0;
    bit          exp_access = 1'b0;
    bit          exp_strobe = 1'b0;
    bit          exp_fault  = 1'b0;
    logic [7:0]  exp_en     = '0;
    logic [12:0] exp_maddr  = '0;
    logic [31:0] exp_wdata  = '0;
    logic [31:0] exp_rdata  = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        else
            checks_passed++;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req_ready"},  32'(bus.req_ready),    32'd1);
        checkOutput({tag, "_resp_valid"}, 32'(bus.resp_valid),   32'd0);
        checkOutput({tag, "_resp_rdata"}, bus.resp_rdata,        32'd0);
        checkOutput({tag, "_resp_fault"}, 32'(bus.resp_fault),   32'd0);
        checkOutput({tag, "_mem_addr"},   32'(bus.mem_addr),     32'd0);
        checkOutput({tag, "_mem_data_o"}, bus.mem_data_o,        32'd0);
        checkOutput({tag, "_mem_data_en"},32'(bus.mem_data_en),  32'd0);
        checkOutput({tag, "_write_en"},   32'(bus.mem_write_en), 32'd0);
    endtask

    // Registered-read BRAM answering the unit's port.
    always @(posedge clk) begin : bram_model
        int a;
        logic [31:0] rd;
        a = int'(bus.mem_addr);
        for (int i = 0; i < 4; i++) rd[8*i +: 8] = bram[(a + i) % MEM_SIZE];
        if (bus.mem_write_en)
            for (int i = 0; i < 4; i++)
                if (bus.mem_data_en[i]) bram[(a + i) % MEM_SIZE] = bus.mem_data_o[8*i +: 8];
        bus.mem_data_i <= rd;
    end

    // Per-cycle comparison against the transaction-level expectations.
    always @(negedge clk) begin
        if (!mon_off) begin
            if (txn_active) begin
                cyc++;
                checkOutput("busy_req_ready", 32'(bus.req_ready), 32'd0);
                checkOutput("write_en", 32'(bus.mem_write_en), 32'(exp_strobe && cyc == 1));
                checkOutput("data_en", 32'(bus.mem_data_en), (exp_access && cyc == 1) ? 32'(exp_en) : 32'd0);
                if (exp_access && cyc == 1) checkOutput("mem_addr", 32'(bus.mem_addr), 32'(exp_maddr));
                if (exp_strobe && cyc == 1) checkOutput("mem_data_o", bus.mem_data_o, exp_wdata);
                checkOutput("resp_valid", 32'(bus.resp_valid), 32'(cyc >= exp_lat));
                if (bus.resp_valid) begin
                    checkOutput("resp_rdata", bus.resp_rdata, exp_rdata);
                    checkOutput("resp_fault", 32'(bus.resp_fault), 32'(exp_fault));
                end
            end else begin
                checkOutput("idle_req_ready", 32'(bus.req_ready), 32'd1);
                checkOutput("idle_resp_valid", 32'(bus.resp_valid), 32'd0);
                checkOutput("idle_write_en", 32'(bus.mem_write_en), 32'd0);
                checkOutput("idle_data_en", 32'(bus.mem_data_en), 32'd0);
            end
        end
    end

    // One complete request/response exchange; abort_cycle>0 pulses rst instead of completing.
    task automatic applyStimulus(input bit wr, input logic [1:0] size, input bit uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int hold, input bit early, input int abort_cycle,
                                 output logic [31:0] got_rdata, output bit got_fault, output int got_lat);
        int n;
        bit fault;
        bit fired;
        int fire_c;
        int ready_cycle;
        longint v;

        n     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        fault = (size == 2'd3) || (longint'(addr) + longint'(n) > longint'(MEM_SIZE));
        exp_access = !fault;
        exp_strobe = !fault && wr;
        exp_fault  = fault;
        exp_lat    = fault ? 1 : (wr ? 2 : 3);
        exp_en     = 8'((1 << n) - 1);
        exp_maddr  = 13'(addr % MEM_SIZE);
        exp_wdata  = wdata;
        exp_rdata  = 32'd0;
        if (!fault && !wr) begin
            v = 0;
            for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[int'(addr) + i]) << (8 * i));
            if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
            exp_rdata = v[31:0];
        end
        if (exp_strobe)
            for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = 8'(wdata >> (8 * i));

        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.resp_ready   = early;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        cyc        = 0;
        txn_active = 1'b1;

        got_lat     = 0;
        got_rdata   = '0;
        got_fault   = 1'b0;
        fired       = 1'b0;
        fire_c      = 0;
        ready_cycle = exp_lat + hold;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (got_lat == 0 && bus.resp_valid) got_lat = c;
            if (c >= ready_cycle) bus.resp_ready = 1'b1;
            if (abort_cycle == c) begin
                rst = 1'b1;
                break;
            end
            if (bus.resp_valid && bus.resp_ready) begin
                fired     = 1'b1;
                fire_c    = c;
                got_rdata = bus.resp_rdata;
                got_fault = bus.resp_fault;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        txn_active     = 1'b0;

        if (abort_cycle > 0) begin
            rst     = 1'b0;
            mon_off = 1'b1;
            @(negedge clk);
            checkResetValues("abort");
            mon_off = 1'b0;
        end else begin
            checkOutput("handshake_seen", 32'(fired), 32'd1);
            if (fired) begin
                checkOutput("latency", 32'(got_lat), 32'(exp_lat));
                checkOutput("handshake_cycle", 32'(fire_c), 32'(early ? exp_lat : exp_lat + hold));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] r;
        bit          f;
        int          l;
        logic [31:0] addr;
        logic [1:0]  size;
        int          sel;

        for (int i = 0; i < MEM_SIZE; i++) begin
            bram[i]    = 8'($urandom);
            ref_mem[i] = bram[i];
        end

        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.resp_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkResetValues("reset");
        mon_off = 1'b0;

        // Word store then load at 0x10.
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, 1'b0, 0, r, f, l);
        checkOutput("t1_store_lat", 32'(l), 32'd2);
        checkOutput("t1_store_rdata", r, 32'd0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 1'b0, 0, r, f, l);
        checkOutput("t1_load_data", r, 32'hDEADBEEF);
        checkOutput("t1_load_lat", 32'(l), 32'd3);

        // Byte store of 0x80 at 0x21; signed and unsigned reloads.
        applyStimulus(1'b1, 2'd0, 1'b0, 32'h21, 32'hABCDEF80, 0, 1'b0, 0, r, f, l);
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h21, 32'h0, 1, 1'b0, 0, r, f, l);
        checkOutput("t2_signed_byte", r, 32'hFFFFFF80);
        applyStimulus(1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 0, 1'b0, 0, r, f, l);
        checkOutput("t2_unsigned_byte", r, 32'h00000080);

        // Range boundary at the top of memory.
        applyStimulus(1'b0, 2'd1, 1'b0, 32'h1FFF, 32'h0, 0, 1'b0, 0, r, f, l);
        checkOutput("t3_half_fault", 32'(f), 32'd1);
        checkOutput("t3_half_rdata", r, 32'd0);
        checkOutput("t3_half_lat", 32'(l), 32'd1);
        applyStimulus(1'b0, 2'd0, 1'b1, 32'h1FFF, 32'h0, 0, 1'b0, 0, r, f, l);
        checkOutput("t3_byte_nofault", 32'(f), 32'd0);

        // Illegal size and wrapping store address.
        applyStimulus(1'b1, 2'd3, 1'b0, 32'h40, 32'h12345678, 0, 1'b0, 0, r, f, l);
        checkOutput("t4_size_fault", 32'(f), 32'd1);
        applyStimulus(1'b1, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h12345678, 0, 1'b0, 0, r, f, l);
        checkOutput("t4_wrap_fault", 32'(f), 32'd1);

        // Response held for five cycles before the consumer takes it.
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, 1'b0, 0, r, f, l);
        checkOutput("t5_held_data", r, 32'hDEADBEEF);

        // Reset during the read wait, then a clean load.
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 1'b0, 2, r, f, l);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 1'b0, 0, r, f, l);
        checkOutput("t6_after_reset", r, 32'hDEADBEEF);

        for (int k = 0; k < 150; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5)       addr = 32'($urandom_range(0, 63));
            else if (sel < 8)  addr = 32'($urandom_range(0, MEM_SIZE - 1));
            else if (sel == 8) addr = 32'(MEM_SIZE - $urandom_range(1, 4));
            else               addr = $urandom;
            size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            applyStimulus(1'($urandom), size, 1'($urandom), addr, $urandom,
                          $urandom_range(0, 3), ($urandom_range(0, 4) == 0), 0, r, f, l);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
